// File: rtl/rv32imc_types.sv
// Shared RV32IMC execute-stage types: divider op codes, divider FSM states
// and small helpers used by the divide unit.
package rv32imc_types;

   // Divide ops as the low two funct3 bits; funct3[2]=1 marks a divide.
   typedef enum logic [1:0] {
      DIV_DIV  = 2'b00,
      DIV_DIVU = 2'b01,
      DIV_REM  = 2'b10,
      DIV_REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_CALC = 2'b01,
      DIV_DONE = 2'b10
   } div_state_e;

   localparam logic [31:0] INT_MIN = 32'h8000_0000;

   // Two's complement magnitude; -2^31 maps to 0x80000000 as an unsigned value.
   function automatic logic [31:0] abs32(input logic [31:0] x);
      return x[31] ? (32'd0 - x) : x;
   endfunction

   // div/rem are signed (funct3[0]=0), divu/remu unsigned.
   function automatic logic op_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

   // rem/remu select the remainder (funct3[1]=1).
   function automatic logic op_rem(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division step: shifts RADIX_BITS dividend bits into the
// partial remainder, retiring one quotient bit per trial subtraction.
module divider_step #(
   parameter int RADIX_BITS = 1
) (
   input  logic [32:0]           rem_in,
   input  logic [31:0]           divisor,
   input  logic [RADIX_BITS-1:0] bits_in,
   output logic [32:0]           rem_out,
   output logic [RADIX_BITS-1:0] q_out
);

   logic [32:0] r;
   logic [32:0] diff;

   // Unrolled shift/compare/subtract chain, MSB quotient bit first.
   // The partial remainder stays below the divisor, so after the shift it
   // fits in 33 bits and diff[32] is a clean borrow flag.
   always_comb begin
      r     = rem_in;
      diff  = '0;
      q_out = '0;
      for (int i = RADIX_BITS - 1; i >= 0; i--) begin
         r    = {r[31:0], bits_in[i]};
         diff = r - {1'b0, divisor};
         if (!diff[32]) begin
            r        = diff;
            q_out[i] = 1'b1;
         end
      end
      rem_out = r;
   end

endmodule

// File: rtl/divider.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU) for EX.
// Restoring radix-2^RADIX_BITS on operand magnitudes; divide-by-zero and
// signed overflow finish in one cycle. RADIX_BITS must be 1, 2 or 4.
module divider
   import rv32imc_types::*;
#(
   parameter int RADIX_BITS = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        start,
   input  logic [2:0]  div_op,
   input  logic        kill,
   output logic [31:0] div_out,
   output logic        div_stall
);

   localparam int          N    = 32 / RADIX_BITS;
   localparam logic [4:0]  LAST = 5'(N - 1);

   div_state_e             state;
   div_op_e                op;
   logic [31:0]            quo;     // dividend bits shift out, quotient bits shift in
   logic [31:0]            dvs;
   logic [32:0]            rem;
   logic [4:0]             cnt;
   logic                   neg_q;
   logic                   neg_r;

   logic                   go;
   logic                   sgn_in;
   logic                   ovf_in;
   logic [31:0]            a_mag;
   logic [31:0]            b_mag;
   logic [32:0]            step_rem;
   logic [RADIX_BITS-1:0]  step_q;
   logic [31:0]            raw_q;
   logic [31:0]            fin_q;
   logic [31:0]            fin_r;

   // Capture decode: a divide request in IDLE that kill does not cancel.
   assign go     = (state == DIV_IDLE) & start & div_op[2] & ~kill;
   assign sgn_in = op_signed(div_op[1:0]);
   assign ovf_in = sgn_in & (a == INT_MIN) & (b == 32'hFFFF_FFFF);
   assign a_mag  = sgn_in ? abs32(a) : a;
   assign b_mag  = sgn_in ? abs32(b) : b;

   // Stall holds EX while a request is being accepted or iterating; kill
   // and reset release the pipe immediately.
   assign div_stall = rst & ~kill &
                      (((state == DIV_IDLE) & start & div_op[2]) | (state == DIV_CALC));

   divider_step #(.RADIX_BITS(RADIX_BITS)) u_step (
      .rem_in  (rem),
      .divisor (dvs),
      .bits_in (quo[31 -: RADIX_BITS]),
      .rem_out (step_rem),
      .q_out   (step_q)
   );

   // Final-step results with sign correction applied.
   assign raw_q = {quo[31-RADIX_BITS:0], step_q};
   assign fin_q = neg_q ? (32'd0 - raw_q) : raw_q;
   assign fin_r = neg_r ? (32'd0 - step_rem[31:0]) : step_rem[31:0];

   // Divider FSM: capture in IDLE, iterate in CALC, present result in DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= DIV_IDLE;
         op      <= DIV_DIV;
         quo     <= '0;
         dvs     <= '0;
         rem     <= '0;
         cnt     <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         div_out <= '0;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (go) begin
                  op    <= div_op_e'(div_op[1:0]);
                  neg_q <= sgn_in & (a[31] ^ b[31]);
                  neg_r <= sgn_in & a[31];
                  quo   <= a_mag;
                  dvs   <= b_mag;
                  rem   <= '0;
                  cnt   <= '0;
                  if (b == 32'd0) begin
                     div_out <= div_op[1] ? a : 32'hFFFF_FFFF;
                     state   <= DIV_DONE;
                  end else if (ovf_in) begin
                     div_out <= div_op[1] ? 32'd0 : INT_MIN;
                     state   <= DIV_DONE;
                  end else begin
                     state   <= DIV_CALC;
                  end
               end
            end
            DIV_CALC: begin
               if (kill) begin
                  state <= DIV_IDLE;
               end else begin
                  quo <= raw_q;
                  rem <= step_rem;
                  cnt <= cnt + 5'd1;
                  if (cnt == LAST) begin
                     div_out <= op_rem(op) ? fin_r : fin_q;
                     state   <= DIV_DONE;
                  end
               end
            end
            DIV_DONE: begin
               div_out <= '0;
               state   <= DIV_IDLE;
            end
            default: state <= DIV_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divider.sv
// Bench for divider: two instances (RADIX_BITS=1 and 2) with independent
// inputs, a cycle-level behavioural model checked every cycle, and directed
// vectors with literal expected results and latencies.
module tb_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a [2];
   logic [31:0] b [2];
   logic [31:0] out [2];
   logic        start [2];
   logic        kill [2];
   logic        stall [2];
   logic [2:0]  op [2];

   int cyc   = 0;
   int tests = 0;
   int fails = 0;

   // model: phase 0 idle, 1 computing, 2 result cycle
   int          ph [2] = '{0, 0};
   int          el [2] = '{0, 0};
   int          lat [2] = '{0, 0};
   logic [31:0] res [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   divider #(.RADIX_BITS(1)) dut0 (
      .clk(clk), .rst(rst), .a(a[0]), .b(b[0]), .start(start[0]),
      .div_op(op[0]), .kill(kill[0]), .div_out(out[0]), .div_stall(stall[0]));

   divider #(.RADIX_BITS(2)) dut1 (
      .clk(clk), .rst(rst), .a(a[1]), .b(b[1]), .start(start[1]),
      .div_op(op[1]), .kill(kill[1]), .div_out(out[1]), .div_stall(stall[1]));

   function automatic int nlat(input int k);
      return (k == 0) ? 33 : 17;
   endfunction

   function automatic bit is_special(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      return (y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
   endfunction

   // RISC-V M-extension semantics in plain arithmetic.
   function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [31:0] q, r;
      if (y == 0) begin
         q = 32'hFFFF_FFFF; r = x;
      end else if (!o[0]) begin
         if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            q = x; r = 0;
         end else begin
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
         end
      end else begin
         q = x / y; r = x % y;
      end
      return o[1] ? r : q;
   endfunction

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s dut%0d cycle %0d: got %h expected %h", nm, k, cyc, act, exp);
      end
   endtask

   // Per-cycle compare against the model, then advance the model across the coming edge.
   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            logic        go, es;
            logic [31:0] eo;
            go = start[k] && op[k][2] && !kill[k];
            if (!rst) begin
               es = 1'b0; eo = 32'd0;
            end else begin
               es = (ph[k] == 0 && go) || (ph[k] == 1 && !kill[k]);
               eo = (ph[k] == 2) ? res[k] : 32'd0;
            end
            chk("model_stall", k, {31'd0, stall[k]}, {31'd0, es});
            chk("model_out", k, out[k], eo);
            if (!rst) ph[k] = 0;
            else case (ph[k])
               0: if (go) begin
                  res[k] = ref_res(op[k], a[k], b[k]);
                  lat[k] = is_special(op[k], a[k], b[k]) ? 1 : nlat(k);
                  el[k]  = 1;
                  ph[k]  = (lat[k] == 1) ? 2 : 1;
               end
               1: if (kill[k]) ph[k] = 0;
                  else begin
                     el[k]++;
                     if (el[k] == lat[k]) ph[k] = 2;
                  end
               default: ph[k] = 0;
            endcase
         end
      end
   end

   // Issue one op on instance k, hold start until the result cycle, check
   // literal result and latency; keep=1 leaves start high for a following op.
   task automatic do_op(input int k, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input int elat, input bit keep);
      int t0;
      bit seen;
      @(posedge clk); #1;
      op[k] = o; a[k] = x; b[k] = y; start[k] = 1'b1;
      t0 = cyc; seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (!stall[k]) seen = 1;
      end
      chk("done_seen", k, {31'd0, seen}, 32'd1);
      chk("latency", k, cyc - t0, elat);
      chk("result", k, out[k], exp);
      if (!keep) begin
         @(posedge clk); #1;
         start[k] = 1'b0;
      end
   endtask

   initial begin
      int t0;
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         a[k] = 0; b[k] = 0; start[k] = 0; kill[k] = 0; op[k] = 3'b000;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out", 0, out[0], 32'd0);
      chk("reset_stall", 0, {31'd0, stall[0]}, 32'd0);
      rst = 1'b1;

      // pin the model with hand-computed values
      chk("ref_div", 0, ref_res(3'b100, 32'd100, 32'd7), 32'd14);
      chk("ref_rem_neg", 0, ref_res(3'b110, 32'hFFFF_FF9C, 32'd7), 32'hFFFF_FFFE);
      chk("ref_divu", 0, ref_res(3'b101, 32'hFFFF_FFFF, 32'd2), 32'h7FFF_FFFF);
      chk("ref_ovf", 0, ref_res(3'b100, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
      chk("ref_remu0", 0, ref_res(3'b111, 32'd37, 32'd0), 32'd37);

      // normal path, RADIX_BITS=1
      do_op(0, 3'b100, 32'd100,         32'd7,         32'd14,         33, 0);
      do_op(0, 3'b110, 32'd100,         32'd7,         32'd2,          33, 0);
      do_op(0, 3'b100, 32'hFFFF_FF9C,   32'd7,         32'hFFFF_FFF2,  33, 0);
      do_op(0, 3'b110, 32'hFFFF_FF9C,   32'd7,         32'hFFFF_FFFE,  33, 0);
      do_op(0, 3'b110, 32'd100,         32'hFFFF_FFF9, 32'd2,          33, 0);
      do_op(0, 3'b101, 32'hFFFF_FFFF,   32'd2,         32'h7FFF_FFFF,  33, 0);
      do_op(0, 3'b111, 32'hFFFF_FFFF,   32'd2,         32'd1,          33, 0);
      do_op(0, 3'b101, 32'd5,           32'hFFFF_FFFF, 32'd0,          33, 0);

      // special cases
      do_op(0, 3'b100, 32'd37,          32'd0,         32'hFFFF_FFFF,  1, 0);
      do_op(0, 3'b111, 32'd37,          32'd0,         32'd37,         1, 0);
      do_op(0, 3'b100, 32'h8000_0000,   32'hFFFF_FFFF, 32'h8000_0000,  1, 0);
      do_op(0, 3'b110, 32'h8000_0000,   32'hFFFF_FFFF, 32'd0,          1, 0);

      // non-divide funct3 is ignored
      @(posedge clk); #1;
      op[0] = 3'b010; a[0] = 32'd9; b[0] = 32'd3; start[0] = 1'b1;
      repeat (3) @(posedge clk);
      #1; start[0] = 1'b0;

      // kill during CALC
      @(posedge clk); #1;
      op[0] = 3'b100; a[0] = 32'd100; b[0] = 32'd7; start[0] = 1'b1; t0 = cyc;
      while (cyc < t0 + 10) begin @(posedge clk); #1; end
      kill[0] = 1'b1;
      @(negedge clk);
      chk("kill_stall", 0, {31'd0, stall[0]}, 32'd0);
      @(posedge clk); #1;
      kill[0] = 1'b0; start[0] = 1'b0;
      repeat (40) @(negedge clk);
      chk("kill_no_result", 0, out[0], 32'd0);

      // reset mid-operation
      @(posedge clk); #1;
      op[0] = 3'b100; a[0] = 32'd100; b[0] = 32'd7; start[0] = 1'b1; t0 = cyc;
      while (cyc < t0 + 5) begin @(posedge clk); #1; end
      rst = 1'b0;
      #1;
      chk("rst_stall", 0, {31'd0, stall[0]}, 32'd0);
      chk("rst_out", 0, out[0], 32'd0);
      start[0] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      do_op(0, 3'b100, 32'd100, 32'd7, 32'd14, 33, 0);

      // back-to-back with start held, both radices
      do_op(0, 3'b100, 32'd9,  32'd3, 32'd3, 33, 1);
      do_op(0, 3'b110, 32'd10, 32'd4, 32'd2, 33, 0);
      do_op(1, 3'b100, 32'd9,  32'd3, 32'd3, 17, 1);
      do_op(1, 3'b110, 32'd10, 32'd4, 32'd2, 17, 0);
      do_op(1, 3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 17, 0);
      do_op(1, 3'b101, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 17, 0);

      repeat (5) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
